// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the serial arithmetic blocks.
//   state_t : control state encoding of the bit-serial subtractor
//             (IDLE = waiting for operands, RUN = one bit per cycle,
//              DONE = result presented until the consumer takes it).
// ---------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtract cell: d = a - b - bin (mod 2), with borrow.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow arrives.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), one bit
// per clock, LSB first. Operands are taken with a valid/ready handshake, and
// the result is held with a valid/ready handshake until it is consumed.
// Ports:
//   clk       in   1      clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      a/b/bin valid
//   in_ready  out  1      block can accept operands (IDLE)
//   a         in   WIDTH  minuend
//   b         in   WIDTH  subtrahend
//   bin       in   1      borrow in
//   out_valid out  1      diff/bout/zero valid (DONE)
//   out_ready in   1      consumer accepts result
//   diff      out  WIDTH  a - b - bin modulo 2^WIDTH
//   bout      out  1      final borrow (a < b + bin, unsigned)
//   zero      out  1      diff is all zeros
// ---------------------------------------------------------------------------
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_dmsb;

  full_subtractor u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_last = (r_cnt == CNT_LAST);

  // New difference bit placed at the MSB; written this way so WIDTH=1 needs
  // no zero-width slice.
  always_comb begin
    w_dmsb           = '0;
    w_dmsb[WIDTH-1]  = w_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_br   <= w_bo;
          r_diff <= (r_diff >> 1) | w_dmsb;
          // Stops at WIDTH-1: the state leaves RUN on that same edge.
          if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_br;
  // Qualified by DONE so the flag is low while the register is mid-shift or
  // cleared by reset.
  assign zero = (r_state == DONE) && (r_diff == '0);

endmodule : serial_subtractor
